// File: rtl/atmega_pll_pkg.sv
// Shared definitions for the fractional PLL block: lock FSM encoding,
// PLLCSR bit positions and the layout of the per-channel increment registers.
package atmega_pll_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOCKING = 2'd1,
        ST_LOCKED  = 2'd2
    } lock_state_t;

    localparam int PLOCK_BIT  = 0;
    localparam int PLLE_BIT   = 1;

    localparam int INC_LO_OFS = 0;
    localparam int INC_HI_OFS = 1;
    localparam int INC_STRIDE = 2;

    function automatic int inc_addr(input int base, input int ch, input int ofs);
        return base + INC_STRIDE * ch + ofs;
    endfunction

endpackage

// File: rtl/atmega_pll_frac_ch.sv
// One output channel: 16-bit phase accumulator whose carry is the ce pulse,
// plus a square wave that toggles on the edge after each pulse.
module atmega_pll_frac_ch (
    input  logic        clk,
    input  logic        rst,
    input  logic        run_i,
    input  logic [15:0] inc_i,
    output logic        ce_o,
    output logic        ck_out_o
);

    logic [15:0] acc_q, acc_d;
    logic        ce_q, ce_d;
    logic        ck_q, ck_d;
    logic [16:0] sum;

    always_comb begin
        sum  = {1'b0, acc_q} + {1'b0, inc_i};
        acc_d = '0;
        ce_d  = 1'b0;
        ck_d  = 1'b0;
        // Leaving the running condition restarts the phase from zero.
        if (run_i) begin
            acc_d = sum[15:0];
            ce_d  = sum[16];
            ck_d  = ck_q ^ ce_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
            ce_q  <= 1'b0;
            ck_q  <= 1'b0;
        end else begin
            acc_q <= acc_d;
            ce_q  <= ce_d;
            ck_q  <= ck_d;
        end
    end

    assign ce_o     = ce_q;
    assign ck_out_o = ck_q;

endmodule

// File: rtl/atmega_pll_frac.sv
// Fractional clock-enable generator with an AVR-style register interface:
// PLLCSR lock control, PLLCHE channel enables and 16-bit per-channel increments.
module atmega_pll_frac
    import atmega_pll_pkg::*;
#(
    parameter int BUS_ADDR_DATA_LEN = 16,
    parameter int CH_COUNT          = 2,
    parameter int LOCK_CYCLES       = 256,
    parameter int CSR_ADDR          = 'h29,
    parameter int CHE_ADDR          = 'h32,
    parameter int INC_ADDR          = 'h60
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [BUS_ADDR_DATA_LEN-1:0] addr,
    input  logic                         wr,
    input  logic                         rd,
    input  logic [7:0]                   bus_in,
    output logic [7:0]                   bus_out,
    output logic                         locked,
    output logic [CH_COUNT-1:0]          ce,
    output logic [CH_COUNT-1:0]          ck_out
);

    localparam int              AW        = BUS_ADDR_DATA_LEN;
    localparam logic [AW-1:0]   CSR_A     = AW'(CSR_ADDR);
    localparam logic [AW-1:0]   CHE_A     = AW'(CHE_ADDR);
    localparam logic [15:0]     LOCK_LOAD = 16'(LOCK_CYCLES - 1);

    logic                plle_q, plle_d;
    logic [CH_COUNT-1:0] che_q, che_d;
    logic [7:0]          temp_q, temp_d;
    lock_state_t         state_q, state_d;
    logic [15:0]         cnt_q, cnt_d;

    logic                csr_hit, che_hit, commit, plock;
    logic [CH_COUNT-1:0] lo_hit, hi_hit, run;
    logic [7:0]          inc_rd [CH_COUNT];

    assign csr_hit = (addr == CSR_A);
    assign che_hit = (addr == CHE_A);
    assign commit  = wr && (|hi_hit);
    assign plock   = (state_q == ST_LOCKED);
    assign locked  = plock;

    always_comb begin
        plle_d = plle_q;
        che_d  = che_q;
        temp_d = temp_q;
        if (wr) begin
            if (csr_hit)  plle_d = bus_in[PLLE_BIT];
            if (che_hit)  che_d  = bus_in[CH_COUNT-1:0];
            if (|lo_hit)  temp_d = bus_in;
        end
    end

    // Lock FSM reacts to the PLLE value being captured this edge, so a
    // disable always beats a counter expiry landing on the same edge.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!plle_d) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_LOCKING;
                    cnt_d   = LOCK_LOAD;
                end
                ST_LOCKING: begin
                    if (commit) begin
                        cnt_d = LOCK_LOAD;
                    end else if (cnt_q == 16'd0) begin
                        state_d = ST_LOCKED;
                    end else begin
                        cnt_d = cnt_q - 16'd1;
                    end
                end
                ST_LOCKED: begin
                    if (commit) begin
                        state_d = ST_LOCKING;
                        cnt_d   = LOCK_LOAD;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            plle_q  <= 1'b0;
            che_q   <= '0;
            temp_q  <= '0;
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            plle_q  <= plle_d;
            che_q   <= che_d;
            temp_q  <= temp_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    for (genvar gi = 0; gi < CH_COUNT; gi++) begin : g_ch
        localparam logic [AW-1:0] LO_A = AW'(inc_addr(INC_ADDR, gi, INC_LO_OFS));
        localparam logic [AW-1:0] HI_A = AW'(inc_addr(INC_ADDR, gi, INC_HI_OFS));

        logic [15:0] inc_q, inc_d;

        assign lo_hit[gi] = (addr == LO_A);
        assign hi_hit[gi] = (addr == HI_A);
        // High-byte write commits the whole word so the channel never sees a torn value.
        assign inc_d      = (wr && hi_hit[gi]) ? {bus_in, temp_q} : inc_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) inc_q <= '0;
            else     inc_q <= inc_d;
        end

        assign inc_rd[gi] = lo_hit[gi] ? inc_q[7:0]  :
                            hi_hit[gi] ? inc_q[15:8] : 8'h00;
        assign run[gi]    = plock && che_q[gi];

        atmega_pll_frac_ch u_ch (
            .clk      (clk),
            .rst      (rst),
            .run_i    (run[gi]),
            .inc_i    (inc_q),
            .ce_o     (ce[gi]),
            .ck_out_o (ck_out[gi])
        );
    end

    always_comb begin
        bus_out = 8'h00;
        if (!rst && rd) begin
            if (csr_hit) bus_out = {6'b0, plle_q, plock};
            if (che_hit) bus_out = 8'(che_q);
            for (int i = 0; i < CH_COUNT; i++) begin
                bus_out = bus_out | inc_rd[i];
            end
        end
    end

endmodule

// File: tb/tb_atmega_pll_frac.sv
// Bench for atmega_pll_frac with LOCK_CYCLES=8 and two channels: register
// vector table followed by lock, pulse-rate, relock, race and reset sequences.
module tb_atmega_pll_frac;

    logic        clk = 1'b0;
    logic        rst, wr, rd;
    logic [15:0] addr;
    logic [7:0]  bus_in, bus_out;
    logic        locked;
    logic [1:0]  ce, ck_out;

    atmega_pll_frac #(
        .BUS_ADDR_DATA_LEN (16),
        .CH_COUNT          (2),
        .LOCK_CYCLES       (8),
        .CSR_ADDR          ('h29),
        .CHE_ADDR          ('h32),
        .INC_ADDR          ('h60)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .addr    (addr),
        .wr      (wr),
        .rd      (rd),
        .bus_in  (bus_in),
        .bus_out (bus_out),
        .locked  (locked),
        .ce      (ce),
        .ck_out  (ck_out)
    );

    always #5 clk = ~clk;

    localparam logic [15:0] A_CSR = 16'h29, A_CHE = 16'h32;
    localparam logic [15:0] A_I0L = 16'h60, A_I0H = 16'h61, A_I1L = 16'h62, A_I1H = 16'h63;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        string       name;
        logic [31:0] exp;
    } sb_t;
    sb_t sbq[$];

    typedef struct {
        bit          is_wr;
        logic [15:0] a;
        logic [7:0]  d;
    } vec_t;
    vec_t vq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic sb_push(input string name, input logic [31:0] exp);
        sb_t e;
        e.name = name;
        e.exp  = exp;
        sbq.push_back(e);
    endtask

    task automatic sb_pop(input logic [31:0] act);
        sb_t e;
        if (sbq.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_empty: got 0x%0h, expected an entry", act);
        end else begin
            e = sbq.pop_front();
            check(e.name, act, e.exp);
        end
    endtask

    task automatic add_vec(input bit w, input logic [15:0] a, input logic [7:0] d);
        vec_t v;
        v.is_wr = w;
        v.a     = a;
        v.d     = d;
        vq.push_back(v);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_reg(input logic [15:0] a, input logic [7:0] d);
        addr   = a;
        bus_in = d;
        wr     = 1'b1;
        @(posedge clk);
        #1;
        wr     = 1'b0;
    endtask

    task automatic rd_chk(input string name, input logic [15:0] a, input logic [7:0] exp);
        sb_push(name, 32'(exp));
        addr = a;
        rd   = 1'b1;
        #1;
        sb_pop(32'(bus_out));
        rd   = 1'b0;
    endtask

    initial begin
        int          pulses;
        logic        ce0_exp, ck0_exp;
        int          np;

        rst = 1'b1; wr = 1'b0; rd = 1'b0; addr = '0; bus_in = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_locked", 32'(locked), 0);
        check("reset_ce", 32'(ce), 0);
        check("reset_ck_out", 32'(ck_out), 0);

        // Register map vectors (FSM stays idle: PLLE never set here).
        add_vec(0, A_CSR, 8'h00); add_vec(0, A_CHE, 8'h00);
        add_vec(0, A_I0L, 8'h00); add_vec(0, A_I1H, 8'h00);
        add_vec(1, A_CHE, 8'hFF); add_vec(0, A_CHE, 8'h03);
        add_vec(1, A_I0L, 8'h34); add_vec(0, A_I0L, 8'h00);
        add_vec(1, A_I0H, 8'h12); add_vec(0, A_I0L, 8'h34); add_vec(0, A_I0H, 8'h12);
        add_vec(1, A_I1L, 8'h55); add_vec(1, A_I1H, 8'h55);
        add_vec(0, A_I1L, 8'h55); add_vec(0, A_I1H, 8'h55);
        add_vec(1, A_CSR, 8'h01); add_vec(0, A_CSR, 8'h00);
        add_vec(0, 16'h0030, 8'h00);
        add_vec(1, A_I0L, 8'h00); add_vec(1, A_I0H, 8'h40); add_vec(0, A_I0H, 8'h40);
        add_vec(1, A_CHE, 8'h01); add_vec(0, A_CHE, 8'h01);
        foreach (vq[i]) begin
            if (vq[i].is_wr) begin
                wr_reg(vq[i].a, vq[i].d);
            end else begin
                rd_chk($sformatf("vec%0d_rd_%0h", i, vq[i].a), vq[i].a, vq[i].d);
                step();
            end
        end
        check("idle_not_locked", 32'(locked), 0);

        // Lock: locked rises exactly 8 edges after the PLLE write edge.
        wr_reg(A_CSR, 8'h02);
        for (int k = 0; k <= 8; k++) begin
            check($sformatf("lock_edge%0d", k), 32'(locked), (k == 8) ? 1 : 0);
            if (k < 8) step();
        end
        rd_chk("csr_locked", A_CSR, 8'h03);
        addr = A_CSR;
        #1;
        check("rd_low_bus_out", 32'(bus_out), 0);

        // INC0=0x4000: first accumulation at edge 9, carry every 4th edge.
        for (int k = 9; k <= 40; k++) begin
            step();
            ce0_exp = (k >= 12) && ((k - 12) % 4 == 0);
            np      = (k > 12) ? ((k - 13) / 4 + 1) : 0;
            ck0_exp = (np % 2) == 1;
            sb_push($sformatf("q4_ce_edge%0d", k), {30'b0, 1'b0, ce0_exp});
            sb_push($sformatf("q4_ck_edge%0d", k), {30'b0, 1'b0, ck0_exp});
            sb_pop(32'(ce));
            sb_pop(32'(ck_out));
        end

        // Channel 1 at 0x5555 over a full 65536-cycle period.
        wr_reg(A_CHE, 8'h03);
        pulses = 0;
        for (int k = 1; k <= 65536; k++) begin
            step();
            pulses += int'(ce[1]);
        end
        check("ch1_pulse_count", 32'(pulses), 21845);

        // Relock on INC0 commit: low write alone must not relock.
        wr_reg(A_I0L, 8'h00);
        check("lo_write_no_relock", 32'(locked), 1);
        wr_reg(A_I0H, 8'h80);
        check("commit_unlock", 32'(locked), 0);
        for (int k = 1; k <= 16; k++) begin
            step();
            check($sformatf("relock_locked_edge%0d", k), 32'(locked), (k >= 8) ? 1 : 0);
            if (k <= 9) begin
                sb_push($sformatf("relock_silent_edge%0d", k), 0);
                sb_pop(32'(ce));
            end else begin
                sb_push($sformatf("half_ce0_edge%0d", k), (k % 2 == 0) ? 1 : 0);
                sb_pop(32'(ce[0]));
            end
        end

        // PLLE=0 captured on the same edge the lock counter expires.
        wr_reg(A_CSR, 8'h00);
        check("disable_unlock", 32'(locked), 0);
        step();
        wr_reg(A_CSR, 8'h02);
        for (int k = 1; k <= 7; k++) begin
            step();
            check($sformatf("race_locking_edge%0d", k), 32'(locked), 0);
        end
        wr_reg(A_CSR, 8'h00);
        for (int k = 0; k < 6; k++) begin
            check($sformatf("race_locked_%0d", k), 32'(locked), 0);
            check($sformatf("race_ce_%0d", k), 32'(ce), 0);
            check($sformatf("race_ck_%0d", k), 32'(ck_out), 0);
            step();
        end
        rd_chk("race_csr", A_CSR, 8'h00);
        step();

        // Reset mid-operation while channels are running.
        wr_reg(A_CSR, 8'h02);
        repeat (19) step();
        check("pre_reset_locked", 32'(locked), 1);
        check("pre_reset_ck0", 32'(ck_out[0]), 1);
        #2;
        rst  = 1'b1;
        addr = A_CSR;
        rd   = 1'b1;
        #1;
        check("rst_locked", 32'(locked), 0);
        check("rst_ce", 32'(ce), 0);
        check("rst_ck_out", 32'(ck_out), 0);
        check("rst_bus_out", 32'(bus_out), 0);
        rd = 1'b0;
        step();
        rst = 1'b0;
        step();
        rd_chk("post_rst_csr", A_CSR, 8'h00); step();
        rd_chk("post_rst_che", A_CHE, 8'h00); step();
        rd_chk("post_rst_i0l", A_I0L, 8'h00); step();
        rd_chk("post_rst_i0h", A_I0H, 8'h00); step();
        rd_chk("post_rst_i1l", A_I1L, 8'h00); step();
        rd_chk("post_rst_i1h", A_I1H, 8'h00); step();
        wr_reg(A_I0H, 8'h11);
        rd_chk("post_rst_temp_lo", A_I0L, 8'h00); step();
        rd_chk("post_rst_temp_hi", A_I0H, 8'h11); step();
        check("post_rst_locked", 32'(locked), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/atmega_pll_frac.md
ATMEGA_PLL_FRAC -- requirements
Module: atmega_pll_frac

Interface
REQ-001 Parameter BUS_ADDR_DATA_LEN, default 16, I/O address bus width.
REQ-002 Parameter CH_COUNT, default 2, number of output channels (1..4).
REQ-003 Parameter LOCK_CYCLES, default 256, clk cycles from enable to lock (2..65535).
REQ-004 Parameter CSR_ADDR, default 'h29, PLLCSR register address.
REQ-005 Parameter CHE_ADDR, default 'h32, PLLCHE channel-enable register address.
REQ-006 Parameter INC_ADDR, default 'h60, base address of per-channel increments: channel i low byte at INC_ADDR+2i, high byte at INC_ADDR+2i+1.
REQ-007 clk  input  1  sole clock; all logic on its rising edge.
REQ-008 rst  input  1  reset, asynchronous, active-high.
REQ-009 addr  input  BUS_ADDR_DATA_LEN  register address.
REQ-010 wr / rd  input  1 each  write strobe / read strobe.
REQ-011 bus_in  input  8  write data.
REQ-012 bus_out  output  8  read data, combinational; 0 when rd low, rst high, or address unmapped.
REQ-013 locked  output  1  mirror of PLOCK.
REQ-014 ce  output  CH_COUNT  per-channel one-cycle clock-enable pulses, registered.
REQ-015 ck_out  output  CH_COUNT  per-channel square wave, toggles on each ce pulse.

Function
REQ-016 PLLCSR: bit1 PLLE (R/W), bit0 PLOCK (read-only, writes ignored), bits 7:2 read 0.
REQ-017 PLLCHE: bit i enables channel i; bits at or above CH_COUNT read 0.
REQ-018 Increment writes: low byte goes to an 8-bit TEMP; high-byte write commits {bus_in, TEMP} to INC[i] in one cycle. Reads return committed values.
REQ-019 Lock FSM states: IDLE, LOCKING, LOCKED.
REQ-020 IDLE -> LOCKING on the edge that captures PLLE=1; lock counter loads LOCK_CYCLES-1.
REQ-021 LOCKING: counter decrements each cycle; at 0 -> LOCKED, so PLOCK reads 1 exactly LOCK_CYCLES cycles after the PLLE write edge.
REQ-022 Any state -> IDLE on the edge capturing PLLE=0; PLOCK is 0 from that edge.
REQ-023 LOCKED or LOCKING + commit of any INC[i] -> LOCKING (relock) with counter reloaded; PLOCK 0 from the commit edge.
REQ-024 In LOCKED with channel enabled: 17-bit sum = acc[i] + INC[i]; acc[i] <= sum[15:0]; ce[i] <= sum[16].
REQ-025 Outside LOCKED, or channel disabled: acc[i] <= 0 and ce[i] <= 0; ck_out[i] holds 0.
REQ-026 ck_out[i] toggles on the edge after each ce[i] pulse; it clears when the channel leaves the running condition.
REQ-027 Pulse rate = f_clk*INC/65536, exact over 65536 cycles. INC=0 gives no pulses; INC=0x8000 pulses every 2nd cycle; INC=0xFFFF pulses 65535 of every 65536 cycles.
REQ-028 Simultaneous PLLE=0 write and lock-counter expiry: IDLE wins.
REQ-029 A CHE write takes effect on the next edge; it does not force a relock.

Reset
REQ-030 rst clears PLLCSR, PLLCHE, TEMP, all INC, acc, lock counter, ce and ck_out; FSM enters IDLE; locked=0.

Structure
REQ-031 The FSM state encoding and register offsets go in a shared package atmega_pll_pkg.
REQ-032 The per-channel accumulator, ce and ck_out logic is one sub-module, atmega_pll_frac_ch, instantiated CH_COUNT times.

Verification
REQ-033 Use LOCK_CYCLES=8. Write PLLCSR=0x02 -> locked rises exactly 8 cycles after the write edge; PLLCSR reads 0x03.
REQ-034 Locked, CHE=0x01, INC0=0x4000 -> ce[0] every 4th cycle; ck_out[0] period 8 cycles.
REQ-035 Locked, INC1=0x5555 on channel 1 -> exactly 21845 pulses in 65536 cycles.
REQ-036 While locked, write INC0 low=0x00 then high=0x80 -> locked falls at the commit edge, ce silent for 8 cycles, then pulses every 2nd cycle.
REQ-037 PLLE=0 written in the same cycle the counter expires -> locked stays 0; all ce and ck_out stay 0.
REQ-038 Assert rst mid-operation -> all outputs 0 immediately; all registers read 0x00.
